// File: rtl/host_ctrl.sv
// host_ctrl: host-side job controller upstream of the multi-core block.
// Accepts a job frame on a 16-bit valid/ready stream (mask, load base, load
// length, read base, read length, then payload). It writes the payload into
// data memory, runs the selected cores until end_process or a watchdog timeout,
// then streams a result window back out of data memory.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready job stream input
//   out_data/out_valid/out_ready result stream output
//   status                    00 idle, 01 load, 10 run, 11 read
//   com_data_in/com_addr/com_wr_en  data-memory port (write data, address, strobe)
//   com_data_out              data-memory read data, one cycle after com_addr
//   n_cores                   core activate mask
//   end_process               core-0 completion flag
//   busy, done, error         job progress flags
module host_ctrl #(
  parameter int NUM_C   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       status,
  output logic [15:0]      com_data_in,
  output logic [15:0]      com_addr,
  output logic             com_wr_en,
  output logic [NUM_C-1:0] n_cores,
  input  logic [15:0]      com_data_out,
  input  logic             end_process,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RD_ADDR = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_RD_OUT  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  // Last RUN cycle index before the watchdog fires (RUN lasts TIMEOUT cycles).
  localparam logic [15:0] RUN_LAST = 16'(TIMEOUT - 1);

  logic [2:0]       state;
  logic             armed;     // low for the first cycle after reset release
  logic [1:0]       hdr_idx;
  logic [NUM_C-1:0] mask;
  logic [NUM_C-1:0] h0_mask;
  logic [15:0]      ld_base;
  logic [15:0]      ld_len;
  logic [15:0]      rd_base;
  logic [15:0]      rd_len;
  logic [15:0]      ld_cnt;
  logic [15:0]      run_cnt;
  logic [15:0]      rd_cnt;
  logic             accept;

  // H0 resized to the core count (zero-extended or truncated).
  always_comb begin
    h0_mask = '0;
    for (int unsigned i = 0; i < NUM_C && i < 16; i++) h0_mask[i] = in_data[i];
  end

  // In LOAD, ready drops as soon as L words have been taken so the stream is
  // never over-read; the final write is still being presented that cycle.
  always_comb begin
    in_ready = 1'b0;
    if (armed) begin
      case (state)
        S_IDLE, S_HDR: in_ready = 1'b1;
        S_LOAD:        in_ready = (ld_cnt != ld_len);
        default:       in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    case (state)
      S_LOAD:                        status = 2'b01;
      S_RUN:                         status = 2'b10;
      S_RD_ADDR, S_RD_WAIT, S_RD_OUT: status = 2'b11;
      default:                       status = 2'b00;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_valid = (state == S_RD_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      armed       <= 1'b0;
      hdr_idx     <= '0;
      mask        <= '0;
      ld_base     <= '0;
      ld_len      <= '0;
      rd_base     <= '0;
      rd_len      <= '0;
      ld_cnt      <= '0;
      run_cnt     <= '0;
      rd_cnt      <= '0;
      com_wr_en   <= 1'b0;
      com_addr    <= '0;
      com_data_in <= '0;
      out_data    <= '0;
      n_cores     <= '0;
      error       <= 1'b0;
    end else begin
      armed     <= 1'b1;
      com_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mask    <= h0_mask;
            error   <= 1'b0;
            hdr_idx <= '0;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0: ld_base <= in_data;
              2'd1: ld_len  <= in_data;
              2'd2: rd_base <= in_data;
              default: begin
                rd_len  <= in_data;
                // Bit 0 forced: end_process only reports core 0.
                n_cores <= mask | NUM_C'(1);
                ld_cnt  <= '0;
                run_cnt <= '0;
                state   <= (ld_len != 16'd0) ? S_LOAD : S_RUN;
              end
            endcase
          end
        end
        S_LOAD: begin
          if (accept) begin
            com_wr_en   <= 1'b1;
            com_addr    <= ld_base + ld_cnt;
            com_data_in <= in_data;
            ld_cnt      <= ld_cnt + 16'd1;
          end else if (ld_cnt == ld_len) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + 16'd1;
          // end_process is ignored in the first RUN cycle and beats a
          // coincident timeout.
          if (run_cnt != 16'd0 && end_process) begin
            if (rd_len != 16'd0) begin
              com_addr <= rd_base;
              rd_cnt   <= '0;
              state    <= S_RD_ADDR;
            end else begin
              n_cores <= '0;
              state   <= S_DONE;
            end
          end else if (run_cnt == RUN_LAST) begin
            error   <= 1'b1;
            n_cores <= '0;
            state   <= S_DONE;
          end
        end
        S_RD_ADDR: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          out_data <= com_data_out;
          state    <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (out_ready) begin
            if (rd_cnt + 16'd1 == rd_len) begin
              n_cores <= '0;
              state   <= S_DONE;
            end else begin
              rd_cnt   <= rd_cnt + 16'd1;
              com_addr <= rd_base + rd_cnt + 16'd1;
              state    <= S_RD_ADDR;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_ctrl.sv
// Self-checking bench for host_ctrl: directed job frames, a data-memory model
// with one-cycle read latency, a queue-based reference of expected writes and
// readback words, and literal checks on latencies and boundary cases.
module tb_host_ctrl;
  localparam int NC = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    status;
  logic [15:0]   com_data_in;
  logic [15:0]   com_addr;
  logic          com_wr_en;
  logic [NC-1:0] n_cores;
  logic [15:0]   com_data_out = '0;
  logic          end_process = 1'b0;
  logic          busy, done, error;

  always #5 clk = ~clk;

  host_ctrl #(.NUM_C(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .status(status), .com_data_in(com_data_in),
    .com_addr(com_addr), .com_wr_en(com_wr_en), .n_cores(n_cores),
    .com_data_out(com_data_out), .end_process(end_process), .busy(busy),
    .done(done), .error(error)
  );

  // Data memory model: write on strobe, read data one cycle after address.
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (com_wr_en) mem[com_addr] <= com_data_in;
    com_data_out <= mem[com_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Reference state
  logic [15:0] frame[$];
  logic [15:0] exp_wr_a[$], exp_wr_d[$], exp_out[$];
  logic [15:0] exp_mask = '0;
  int          wr_cyc[$];
  logic [15:0] wr_log[$], out_log[$];
  int          done_cnt = 0, done_cyc = 0, first_run = 0, last_run = 0, ov_cnt = 0;
  logic        done_err = 1'b0;
  logic        p_ov = 1'b0, p_or = 1'b0, p_done = 1'b0;
  logic [15:0] p_od = '0, p_addr = '0;
  logic [1:0]  p_status = 2'b00;

  // Per-cycle compare process
  always @(negedge clk) begin
    if (!rst_q) begin
      if (com_wr_en) begin
        chk("wr_status", {30'd0, status}, 32'd1);
        if (exp_wr_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_extra: got addr %h expected no write", com_addr);
        end else begin
          chk("wr_addr", {16'd0, com_addr}, {16'd0, exp_wr_a.pop_front()});
          chk("wr_data", {16'd0, com_data_in}, {16'd0, exp_wr_d.pop_front()});
        end
        wr_cyc.push_back(cyc);
        wr_log.push_back(com_addr);
      end
      chk("n_cores", {16'd0, n_cores}, (status != 2'b00) ? {16'd0, exp_mask} : 32'd0);
      if (status[1]) chk("in_ready_blocked", {31'd0, in_ready}, 32'd0);
      if (status != 2'b00 || done) chk("busy", {31'd0, busy}, 32'd1);
      if (p_ov && !p_or) begin
        chk("ov_hold", {31'd0, out_valid}, 32'd1);
        chk("od_hold", {16'd0, out_data}, {16'd0, p_od});
        chk("addr_hold", {16'd0, com_addr}, {16'd0, p_addr});
      end
      if (out_valid) begin
        ov_cnt++;
        chk("out_status", {30'd0, status}, 32'd3);
        if (out_ready) begin
          if (exp_out.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out_extra: got %h expected no word", out_data);
          end else begin
            chk("out_data", {16'd0, out_data}, {16'd0, exp_out.pop_front()});
          end
          out_log.push_back(out_data);
        end
      end
      if (status == 2'b10) begin
        if (p_status != 2'b10) first_run = cyc;
        last_run = cyc;
      end
      if (done) begin
        chk("done_single", {31'd0, p_done}, 32'd0);
        done_cnt++;
        done_cyc = cyc;
        done_err = error;
      end
    end
    p_ov = out_valid; p_or = out_ready; p_od = out_data;
    p_addr = com_addr; p_done = done; p_status = status;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic prepare_job(input bit rd);
    logic [15:0] a;
    exp_mask = frame[0] | 16'h0001;
    for (int k = 0; k < int'(frame[2]); k++) begin
      a = frame[1] + 16'(k);
      exp_wr_a.push_back(a);
      exp_wr_d.push_back(frame[5 + k]);
      ref_mem[a] = frame[5 + k];
    end
    if (rd)
      for (int j = 0; j < int'(frame[4]); j++) begin
        a = frame[3] + 16'(j);
        exp_out.push_back(ref_mem[a]);
      end
  endtask

  task automatic send_word(input logic [15:0] w);
    bit hs, ok;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire("in_handshake");
  endtask

  task automatic send_frame(input int from, input bit stall);
    for (int i = from; i < frame.size(); i++) begin
      if (stall && (i % 3 == 2)) begin
        in_valid = 1'b0;
        tick();
      end
      send_word(frame[i]);
    end
    // Offer one more word: it must not be taken.
    in_data  = 16'hDEAD;
    in_valid = 1'b1;
    chk("in_ready_after_frame", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_status(input logic [1:0] s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (status == s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) expire("wait_status");
  endtask

  task automatic wait_done;
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire("wait_done");
  endtask

  task automatic pulse_end(input int delay);
    wait_status(2'b10);
    repeat (delay) tick();
    end_process = 1'b1;
    tick();
    end_process = 1'b0;
  endtask

  task automatic check_reset_vals;
    chk("rst_status", {30'd0, status}, 32'd0);
    chk("rst_wr_en", {31'd0, com_wr_en}, 32'd0);
    chk("rst_addr", {16'd0, com_addr}, 32'd0);
    chk("rst_wdata", {16'd0, com_data_in}, 32'd0);
    chk("rst_ncores", {16'd0, n_cores}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
  endtask

  task automatic release_reset;
    rst = 1'b0;
    chk("in_ready_rst_cycle", {31'd0, in_ready}, 32'd0);
    tick();
    chk("in_ready_rise", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int w0, o0, d0, v0, held;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    repeat (3) tick();
    check_reset_vals();
    release_reset();

    // Test 1: basic job, end_process 5 cycles into RUN
    w0 = wr_log.size(); o0 = out_log.size(); d0 = done_cnt;
    frame = '{16'h0006, 16'h0010, 16'd3, 16'h0010, 16'd3, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    prepare_job(1'b1);
    send_frame(0, 1'b0);
    wait_status(2'b10);
    chk("t1_ncores_lit", {16'd0, n_cores}, 32'h0007);
    pulse_end(5);
    wait_done();
    chk("t1_nwr", wr_log.size() - w0, 3);
    chk("t1_wr0", {16'd0, wr_log[w0]}, 32'h0010);
    chk("t1_wr2", {16'd0, wr_log[w0 + 2]}, 32'h0012);
    chk("t1_wr_consec", wr_cyc[w0 + 2] - wr_cyc[w0], 2);
    chk("t1_nout", out_log.size() - o0, 3);
    chk("t1_out0", {16'd0, out_log[o0]}, 32'hAAAA);
    chk("t1_out1", {16'd0, out_log[o0 + 1]}, 32'hBBBB);
    chk("t1_out2", {16'd0, out_log[o0 + 2]}, 32'hCCCC);
    chk("t1_ndone", done_cnt - d0, 1);
    chk("t1_err", {31'd0, done_err}, 32'd0);

    // Test 2: L = 0, R = 0, end_process held high
    w0 = wr_log.size(); v0 = ov_cnt; d0 = done_cnt;
    frame = '{16'h0001, 16'h0020, 16'd0, 16'h0030, 16'd0};
    prepare_job(1'b1);
    end_process = 1'b1;
    send_frame(0, 1'b0);
    wait_done();
    end_process = 1'b0;
    chk("t2_nwr", wr_log.size() - w0, 0);
    chk("t2_nov", ov_cnt - v0, 0);
    chk("t2_run_len", last_run - first_run, 1);
    chk("t2_done_after_run", done_cyc - last_run, 1);
    chk("t2_ndone", done_cnt - d0, 1);

    // Test 3: watchdog timeout
    v0 = ov_cnt; d0 = done_cnt;
    frame = '{16'h0002, 16'h0040, 16'd1, 16'h0040, 16'd1, 16'h1234};
    prepare_job(1'b0);
    send_frame(0, 1'b0);
    wait_done();
    chk("t3_run_len", last_run - first_run + 1, 8);
    chk("t3_done_after_run", done_cyc - last_run, 1);
    chk("t3_done_err", {31'd0, done_err}, 32'd1);
    chk("t3_nov", ov_cnt - v0, 0);
    chk("t3_ndone", done_cnt - d0, 1);
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);

    // Test 4: address wrap, input stalls; error clears on H0
    w0 = wr_log.size(); o0 = out_log.size();
    frame = '{16'h8000, 16'hFFFF, 16'd2, 16'hFFFF, 16'd2, 16'h1111, 16'h2222};
    prepare_job(1'b1);
    chk("t4_err_before_h0", {31'd0, error}, 32'd1);
    send_word(frame[0]);
    chk("t4_err_after_h0", {31'd0, error}, 32'd0);
    send_frame(1, 1'b1);
    pulse_end(2);
    wait_done();
    chk("t4_wr0", {16'd0, wr_log[w0]}, 32'hFFFF);
    chk("t4_wr1", {16'd0, wr_log[w0 + 1]}, 32'h0000);
    chk("t4_out0", {16'd0, out_log[o0]}, 32'h1111);
    chk("t4_out1", {16'd0, out_log[o0 + 1]}, 32'h2222);

    // Test 5: output stall of 10 cycles
    o0 = out_log.size();
    frame = '{16'h0004, 16'h0100, 16'd2, 16'h0100, 16'd2, 16'h5A5A, 16'hA5A5};
    prepare_job(1'b1);
    out_ready = 1'b0;
    send_frame(0, 1'b0);
    pulse_end(3);
    held = 0;
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    if (!out_valid) expire("t5_wait_out_valid");
    for (int i = 0; i < 10; i++) begin
      if (out_valid) held++;
      chk("t5_stall_data", {16'd0, out_data}, 32'h5A5A);
      chk("t5_stall_addr", {16'd0, com_addr}, 32'h0100);
      tick();
    end
    chk("t5_held", held, 10);
    out_ready = 1'b1;
    wait_done();
    chk("t5_out0", {16'd0, out_log[o0]}, 32'h5A5A);
    chk("t5_out1", {16'd0, out_log[o0 + 1]}, 32'hA5A5);

    // Test 6: reset in the middle of LOAD, then a fresh frame
    frame = '{16'h0008, 16'h0200, 16'd4, 16'h0200, 16'd0, 16'h0101, 16'h0202};
    exp_mask = 16'h0009;
    exp_wr_a.push_back(16'h0200); exp_wr_d.push_back(16'h0101);
    exp_wr_a.push_back(16'h0201); exp_wr_d.push_back(16'h0202);
    ref_mem[16'h0200] = 16'h0101;
    ref_mem[16'h0201] = 16'h0202;
    for (int i = 0; i < 7; i++) send_word(frame[i]);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check_reset_vals();
    chk("t6_wr_drained", exp_wr_a.size(), 0);
    exp_wr_a.delete(); exp_wr_d.delete(); exp_out.delete();
    release_reset();
    o0 = out_log.size(); d0 = done_cnt;
    frame = '{16'h0003, 16'h0300, 16'd2, 16'h0200, 16'd3, 16'h7777, 16'h8888};
    prepare_job(1'b1);
    send_frame(0, 1'b0);
    pulse_end(1);
    wait_done();
    chk("t6_out0", {16'd0, out_log[o0]}, 32'h0101);
    chk("t6_out1", {16'd0, out_log[o0 + 1]}, 32'h0202);
    chk("t6_out2", {16'd0, out_log[o0 + 2]}, 32'h0000);
    chk("t6_ndone", done_cnt - d0, 1);
    chk("t6_out_drained", exp_out.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/host_ctrl.md
# host_ctrl

Host-side job controller that sits directly upstream of the multi-core `top` block and drives its communication port. It receives a job as a 16-bit valid/ready word stream, writes the payload into data memory, enables the requested cores, and runs them until `end_process` or a watchdog timeout. It then reads back a result window from data memory and emits it on a 16-bit valid/ready output stream.

## Interface
- `NUM_C`, 16, number of cores; width of `n_cores`.
- `TIMEOUT`, 65535, maximum RUN cycles before abort; must be ≥ 1.

- `clk` in 1, system clock; all logic is rising-edge.
- `rst` in 1, synchronous, active-high reset.
- `in_data` in 16, job stream word.
- `in_valid` in 1, `in_data` is valid.
- `in_ready` out 1, block accepts a word this cycle.
- `out_data` out 16, result word.
- `out_valid` out 1, `out_data` is valid.
- `out_ready` in 1, sink accepts the result word.
- `status` out 2, mode of `top`: 2'b00 IDLE, 2'b01 LOAD, 2'b10 RUN, 2'b11 READ.
- `com_data_in` out 16, write data to the data-memory port.
- `com_addr` out 16, data-memory address.
- `com_wr_en` out 1, data-memory write strobe.
- `n_cores` out NUM_C, core activate mask.
- `com_data_out` in 16, data-memory read data; valid 1 cycle after `com_addr` is presented.
- `end_process` in 1, core-0 completion flag.
- `busy` out 1, high in every state except IDLE.
- `done` out 1, one-cycle pulse when a job finishes.
- `error` out 1, set on timeout; cleared when the next job header is accepted.

## Operation
- Job frame, in order:
  - H0 = core mask
  - H1 = load base
  - H2 = load length L
  - H3 = read base
  - H4 = read length R
  - then L payload words
- Words are consumed only on `in_valid & in_ready`.
- States: IDLE → HDR → LOAD → RUN → READ → DONE → IDLE.
- IDLE:
  - `in_ready` = 1.
  - The first accepted word is H0; capture it and go to HDR.
- HDR:
  - Capture H1–H4, one per handshake.
  - After H4, go to LOAD if L ≠ 0, else go to RUN.
- Core mask:
  - `n_cores` = H0 with bit 0 forced to 1, because `end_process` reflects core 0 only.
  - `n_cores` is driven from HDR exit until DONE, and is 0 otherwise.
- LOAD:
  - Payload word k, accepted in cycle t, produces in cycle t+1: `com_wr_en` = 1, `com_addr` = (H1 + k) mod 2^16, `com_data_in` = the word.
  - `com_wr_en` = 0 in any cycle with no accept in the previous cycle.
  - `in_ready` drops in the cycle after the L-th accept; the stream is not over-read.
- RUN:
  - `status` = 2'b10 and `in_ready` = 0.
  - A cycle counter starts at 0.
  - `end_process` is ignored in the first RUN cycle.
  - `end_process` = 1 goes to READ, or to DONE if R = 0.
  - Counter reaching TIMEOUT sets `error` and goes to DONE with no readback.
  - If `end_process` and the timeout coincide, `end_process` wins.
- READ: substates ADDR, WAIT, OUT.
  - ADDR drives `com_addr` = (H3 + j) mod 2^16.
  - WAIT captures `com_data_out` into `out_data`.
  - OUT holds `out_valid` = 1 with stable data until `out_ready`.
  - After the R-th accept, go to DONE; otherwise j+1 and back to ADDR.
- DONE: `done` = 1 for one cycle, `n_cores` = 0, then IDLE.
- Length arithmetic: L and R are unsigned 16-bit; internal counters are 16-bit. Address wrap from 16'hFFFF to 16'h0000 is legal.

## Timing
- Reset values:
  - `status` = 2'b00
  - `com_wr_en`, `com_addr`, `com_data_in` = 0
  - `n_cores` = 0
  - `in_ready` = 0
  - `out_valid` = 0, `out_data` = 0
  - `busy` = 0, `done` = 0, `error` = 0
- `in_ready` rises the cycle after `rst` deasserts.
- Reset mid-job (any state): all outputs return to reset values on the next edge. Any partially loaded data stays in memory and is not cleaned up.
- `status` = 2'b01 from HDR exit (with L ≠ 0) through the cycle carrying the last `com_wr_en`. RUN begins on the next cycle, so `status` never leaves LOAD while `com_wr_en` = 1.
- READ throughput: at most one word per 3 cycles. Latency from the ADDR cycle to `out_valid` is 2 cycles.
- `status` = 2'b11 during READ.
- `out_valid` never drops without a handshake.
- Input stalls (`in_valid` = 0) in HDR or LOAD are unbounded. Output stalls are unbounded.

## Test plan
- Reset, then frame {0x0006, 0x0010, 3, 0x0010, 3, 0xAAAA, 0xBBBB, 0xCCCC}, `end_process` pulsed 5 cycles into RUN, memory model echoing writes:
  - writes to 0x10–0x12 on three consecutive cycles
  - `n_cores` = 0x0007
  - output stream 0xAAAA, 0xBBBB, 0xCCCC
  - one `done` pulse, `error` = 0
- L = 0, R = 0, `end_process` asserted: no `com_wr_en`, no `out_valid`, `done` on the cycle after leaving RUN.
- TIMEOUT = 8, `end_process` held 0: `error` = 1 after 8 RUN cycles, no readback, `done` pulse. `error` clears when the next H0 is accepted.
- Load base 0xFFFF, L = 2: writes land at 0xFFFF then 0x0000. Readback with base 0xFFFF, R = 2 returns both words.
- `out_ready` held low 10 cycles in READ: `out_data` stable, `out_valid` held, and no new `com_addr` is issued.
- `rst` asserted mid-LOAD: next cycle all outputs are at reset values. A fresh frame afterward completes correctly.
